lcd_ctrl: RTL and testbench

- Downstream consumer of the LSU LCD I/O register (the `o_io_lcd` word, io slot 4).
- Converts software-written command words into HD44780-style bus cycles on the LCD pins, with correct setup, enable-pulse, hold and execution timing.
- Gives software a busy/done indication so it can pace writes to the LCD register.

---
 rtl/lcd_ctrl.sv | 149 ++++++++++++++
 tb/tb_lcd_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD bus sequencer fed by the LSU LCD I/O register word.
// Turns GO-toggle requests into setup/enable/hold/execute bus cycles with a one-deep pending slot.
module lcd_ctrl #(
  parameter int unsigned INIT_CYC      = 750000,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned EN_CYC        = 12,
  parameter int unsigned HOLD_CYC      = 4,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned LONG_EXEC_CYC = 82000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_reg,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_done_tgl,
  output logic        o_overrun
);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_HOLD,
    S_EXEC
  } state_t;

  localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LEXEC_LD = CNT_W'(LONG_EXEC_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             timer_end;
  logic             go_prev_q;
  logic             pending_q;
  logic [8:0]       slot_q;
  logic             act_rs_q;
  logic [7:0]       act_data_q;
  logic             on_q;
  logic             done_q;
  logic             overrun_q;
  logic             req;
  logic             consume;
  logic             long_exec;
  logic             unused_bits;

  assign unused_bits = ^{i_lcd_reg[29:10], i_lcd_reg[8]};

  assign req       = i_lcd_reg[30] ^ go_prev_q;
  assign timer_end = (timer_q == '0);
  assign long_exec = !act_rs_q && (act_data_q[7:2] == '0);
  assign consume   = pending_q && (state_d == S_SETUP) &&
                     ((state_q == S_IDLE) || (state_q == S_EXEC));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_INIT_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // INIT_WAIT counts up from the reset value of 0; every other state reloads
  // the timer on entry and counts down to 0.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      S_INIT_WAIT: if (timer_q == INIT_LD) state_d = S_IDLE;
      S_IDLE:      if (pending_q) state_d = S_SETUP;
      S_SETUP:     if (timer_end) state_d = S_ENABLE;
      S_ENABLE:    if (timer_end) state_d = S_HOLD;
      S_HOLD:      if (timer_end) state_d = S_EXEC;
      S_EXEC:      if (timer_end) state_d = pending_q ? S_SETUP : S_IDLE;
      default:     state_d = S_INIT_WAIT;
    endcase

    if (state_d != state_q) begin
      unique case (state_d)
        S_SETUP:  timer_d = SETUP_LD;
        S_ENABLE: timer_d = EN_LD;
        S_HOLD:   timer_d = HOLD_LD;
        S_EXEC:   timer_d = long_exec ? LEXEC_LD : EXEC_LD;
        default:  timer_d = '0;
      endcase
    end else if (state_q == S_INIT_WAIT) begin
      timer_d = timer_q + CNT_W'(1);
    end else if (state_q != S_IDLE) begin
      timer_d = timer_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      timer_q    <= '0;
      go_prev_q  <= 1'b0;
      pending_q  <= 1'b0;
      slot_q     <= '0;
      act_rs_q   <= 1'b0;
      act_data_q <= '0;
      on_q       <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      go_prev_q <= i_lcd_reg[30];
      on_q      <= i_lcd_reg[31];

      if (consume) begin
        {act_rs_q, act_data_q} <= slot_q;
      end

      // A request landing on the consuming edge refills the slot without overrun.
      if (req) begin
        slot_q    <= {i_lcd_reg[9], i_lcd_reg[7:0]};
        pending_q <= 1'b1;
        if (pending_q && !consume) overrun_q <= 1'b1;
      end else if (consume) begin
        pending_q <= 1'b0;
      end

      if ((state_q == S_EXEC) && timer_end) begin
        done_q <= ~done_q;
      end
    end
  end

  always_comb begin
    o_lcd_on   = on_q;
    o_lcd_en   = (state_q == S_ENABLE);
    o_lcd_rs   = act_rs_q;
    o_lcd_rw   = 1'b0;
    o_lcd_data = act_data_q;
    o_busy     = (state_q != S_IDLE) || pending_q;
    o_done_tgl = done_q;
    o_overrun  = overrun_q;
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed scoreboard bench for lcd_ctrl using shortened timing parameters.
module tb_lcd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lcd_reg;
  logic        lcd_on, lcd_en, lcd_rs, lcd_rw, busy, done_tgl, overrun;
  logic [7:0]  lcd_data;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int en_rises = 0;

  logic [8:0] exp_q[$];
  int         rise_q[$];
  int         done_q[$];

  logic [8:0] d1 = '0, d2 = '0, cur = '0;
  logic       en_prev = 1'b0, done_prev = 1'b0;
  int         en_w = 0;

  lcd_ctrl #(
    .INIT_CYC(10), .SETUP_CYC(2), .EN_CYC(3), .HOLD_CYC(2),
    .EXEC_CYC(5), .LONG_EXEC_CYC(20), .CNT_W(20)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_lcd_reg(lcd_reg),
    .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
    .o_lcd_data(lcd_data), .o_busy(busy), .o_done_tgl(done_tgl), .o_overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rise(input int exp);
    int got;
    got = -1;
    if (rise_q.size() > 0) got = rise_q.pop_front();
    chk("en_rise_cyc", got, exp);
  endtask

  task automatic check_done(input int exp);
    int got;
    got = -1;
    if (done_q.size() > 0) got = done_q.pop_front();
    chk("done_cyc", got, exp);
  endtask

  // Bus monitor: pops the scoreboard on every EN rising edge.
  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      en_rises++;
      rise_q.push_back(cyc);
      en_w = 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {23'b0, lcd_rs, lcd_data}, 32'hffff_ffff);
      end else begin
        cur = exp_q.pop_front();
        chk("en_rise_bus", {23'b0, lcd_rs, lcd_data}, {23'b0, cur});
        chk("setup_bus", {23'b0, d2}, {23'b0, cur});
      end
    end else if (lcd_en) begin
      en_w++;
    end else if (en_prev && rst_n) begin
      chk("en_width", en_w, 3);
      chk("hold_bus", {23'b0, lcd_rs, lcd_data}, {23'b0, cur});
    end
    if (done_tgl !== done_prev) done_q.push_back(cyc);
    d2 = d1;
    d1 = {lcd_rs, lcd_data};
    en_prev = lcd_en;
    done_prev = done_tgl;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, e, base, rises0;

    // 1: reset state and init wait
    rst_n = 1'b0;
    lcd_reg = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_outs", {lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, done_tgl, overrun}, 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++; else break;
    end
    chk("init_busy_cycles", n, 10);
    chk("idle_outs", {lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, done_tgl}, 0);

    // 2: data write 0x41, RS=1
    @(posedge clk); #1;
    lcd_reg = 32'h4000_0241;
    e = cyc + 1;
    exp_q.push_back(9'h141);
    repeat (20) @(negedge clk);
    check_rise(e + 3);
    check_done(e + 13);
    chk("busy_after_write", busy, 0);

    // 3: clear command, long exec
    @(posedge clk); #1;
    lcd_reg = 32'h0000_0001;
    e = cyc + 1;
    exp_q.push_back(9'h001);
    repeat (35) @(negedge clk);
    check_rise(e + 3);
    check_done(e + 28);
    chk("busy_after_clear", busy, 0);

    // 4: back-to-back writes, second one queued
    @(negedge clk);
    base = cyc;
    lcd_reg = 32'hC000_0248;
    e = base + 1;
    exp_q.push_back(9'h148);
    n = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (cyc == base + 1) chk("lcd_on_latency", lcd_on, 1);
      if (cyc == base + 2) begin
        lcd_reg = 32'h8000_0249;
        exp_q.push_back(9'h149);
      end
      if (cyc >= e && cyc <= e + 24 && !busy) n++;
    end
    chk("busy_held_cycles_low", n, 0);
    check_rise(e + 3);
    check_rise(e + 15);
    check_done(e + 13);
    check_done(e + 25);
    chk("no_overrun", overrun, 0);
    chk("busy_end_b2b", busy, 0);

    // 5: three toggles, middle one overwritten
    @(negedge clk);
    base = cyc;
    lcd_reg = 32'h4000_0010;
    e = base + 1;
    exp_q.push_back(9'h010);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (cyc == base + 3) lcd_reg = 32'h0000_0011;
      if (cyc == base + 4) chk("overrun_single_pending", overrun, 0);
      if (cyc == base + 5) begin
        lcd_reg = 32'h4000_0012;
        exp_q.push_back(9'h012);
      end
    end
    chk("overrun_set", overrun, 1);
    check_rise(e + 3);
    check_rise(e + 15);
    check_done(e + 13);
    check_done(e + 25);

    // 6: reset during ENABLE discards in-flight and pending requests
    @(negedge clk);
    base = cyc;
    lcd_reg = 32'h0000_0020;
    e = base + 1;
    exp_q.push_back(9'h020);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cyc == base + 2) lcd_reg = 32'h4000_0021;
    end
    chk("en_before_reset", lcd_en, 1);
    rst_n = 1'b0;
    #1;
    chk("en_async_reset", lcd_en, 0);
    chk("busy_in_reset", busy, 1);
    lcd_reg = '0;
    check_rise(e + 3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_q.delete();
    rises0 = en_rises;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++; else break;
    end
    chk("reinit_busy_cycles", n, 10);
    repeat (40) @(negedge clk);
    chk("no_stale_pulse", en_rises, rises0);
    chk("no_stale_done", done_q.size(), 0);
    chk("post_reset_outs", {lcd_rs, lcd_data, done_tgl, overrun, busy}, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
